fv_ct_add: RTL and testbench

- Streaming stage directly downstream of the R2×Rq polynomial multiplier in the FV encryption datapath.
- Completes one ciphertext component per polynomial, coefficient by coefficient: c[i] = z[i] + e[i] + Delta·m[i] mod 2^QW, with Delta = 2^(QW-1) (t = 2).
- The multiplier ignores backpressure on its product stream, so the product stream is absorbed into an internal FIFO.
- The error and message streams, and the output, are fully handshaked.

---
 rtl/fv_pkg.sv | 28 ++
 rtl/fv_ct_add_if.sv | 10 +
 rtl/poly_fifo.sv | 41 ++++
 rtl/fv_ct_add.sv | 117 +++++++++++
 tb/tb_fv_ct_add.sv | 295 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fv_pkg.sv
// Shared types and constants for the FV ciphertext-add stage.
package fv_pkg;

  localparam int unsigned N_DEF     = 16;
  localparam int unsigned QW_DEF    = 64;
  localparam int unsigned EW_DEF    = 8;
  localparam int unsigned DEPTH_DEF = 16;
  localparam int unsigned QW_MAX    = 64;

  typedef enum logic [1:0] {
    ST_RESET     = 2'd0,
    ST_STREAM    = 2'd1,
    ST_LAST_HOLD = 2'd2
  } state_t;

  // Delta = q/t with t = 2, i.e. the top bit of a qw-bit coefficient.
  function automatic logic [QW_MAX-1:0] delta(input int unsigned qw);
    return QW_MAX'(1) << (qw - 1);
  endfunction

  // Sign-extend the low w bits of x to QW_MAX bits.
  function automatic logic [QW_MAX-1:0] sext(input logic [QW_MAX-1:0] x, input int unsigned w);
    int unsigned sh;
    sh = QW_MAX - w;
    return $unsigned($signed(x << sh) >>> sh);
  endfunction

endpackage

// File: rtl/fv_ct_add_if.sv
// Valid/ready stream with a last tag.
interface axis_if #(parameter int unsigned W = 8);
  logic         vld;
  logic         rdy;
  logic         last;
  logic [W-1:0] data;

  modport in  (input vld, input data, input last, output rdy);
  modport out (output vld, output data, output last, input rdy);
endinterface

// File: rtl/poly_fifo.sv
// Synchronous FIFO with first-word-fall-through head.
module poly_fifo #(
  parameter int unsigned W     = 65,
  parameter int unsigned DEPTH = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign dout  = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
    end
  end

endmodule

// File: rtl/fv_ct_add.sv
// FV ciphertext completion: c[i] = z[i] + e[i] + Delta*m[i] mod 2^QW.
// Product stream z is buffered since its source ignores backpressure.
module fv_ct_add
  import fv_pkg::*;
#(
  parameter int unsigned N     = N_DEF,
  parameter int unsigned QW    = QW_DEF,
  parameter int unsigned EW    = EW_DEF,
  parameter int unsigned DEPTH = DEPTH_DEF
) (
  input  logic clk,
  input  logic s_rst,
  axis_if.in   z,
  axis_if.in   e,
  axis_if.in   m,
  axis_if.out  c,
  output logic err_ovf,
  output logic err_frame
);

  localparam int unsigned   CW    = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned   FW    = QW + 1;
  localparam logic [QW-1:0] DELTA = QW'(delta(QW));

  state_t          state;
  state_t          state_nxt;
  logic [CW-1:0]   cnt;
  logic            cnt_last;
  logic            fire;
  logic            push;
  logic            pop;
  logic            full;
  logic            empty;
  logic            z_drop;
  logic [FW-1:0]   head;
  logic [QW-1:0]   sum;
  logic            c_vld;
  logic            c_last;
  logic [QW-1:0]   c_data;

  poly_fifo #(.W(FW), .DEPTH(DEPTH)) u_fifo (
    .clk  (clk),
    .rst  (s_rst),
    .push (push),
    .pop  (pop),
    .din  ({z.last, z.data}),
    .dout (head),
    .full (full),
    .empty(empty)
  );

  assign cnt_last = (cnt == CW'(N - 1));
  assign sum      = head[QW-1:0] + QW'(sext(QW_MAX'(e.data), EW)) + (m.data ? DELTA : '0);

  assign c.vld  = c_vld;
  assign c.last = c_last;
  assign c.data = c_data;

  always_ff @(posedge clk) begin
    if (s_rst) state <= ST_RESET;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_RESET:     state_nxt = ST_STREAM;
      ST_STREAM:    if (fire && cnt_last) state_nxt = ST_LAST_HOLD;
      ST_LAST_HOLD: if (c_vld && c.rdy)   state_nxt = ST_STREAM;
      default:      state_nxt = ST_RESET;
    endcase
  end

  // Join of FIFO head, e and m; a pop frees a slot for a same-cycle push.
  always_comb begin
    fire   = 1'b0;
    push   = 1'b0;
    z_drop = 1'b0;
    e.rdy  = 1'b0;
    m.rdy  = 1'b0;
    z.rdy  = 1'b0;
    fire   = (state == ST_STREAM) && !s_rst && !empty && e.vld && m.vld && (!c_vld || c.rdy);
    e.rdy  = fire;
    m.rdy  = fire;
    z.rdy  = (state != ST_RESET) && !s_rst && !full;
    push   = z.vld && (state != ST_RESET) && !s_rst && (!full || fire);
    z_drop = z.vld && (state != ST_RESET) && !s_rst && full && !fire;
  end

  assign pop = fire;

  // Output register, coefficient counter and sticky error flags.
  always_ff @(posedge clk) begin
    if (s_rst) begin
      c_vld     <= 1'b0;
      c_last    <= 1'b0;
      c_data    <= '0;
      cnt       <= '0;
      err_ovf   <= 1'b0;
      err_frame <= 1'b0;
    end else begin
      if (fire) begin
        c_vld  <= 1'b1;
        c_last <= cnt_last;
        c_data <= sum;
        cnt    <= cnt_last ? '0 : cnt + CW'(1);
        if ((head[QW] != cnt_last) || (e.last != cnt_last) || (m.last != cnt_last))
          err_frame <= 1'b1;
      end else if (c_vld && c.rdy) begin
        c_vld  <= 1'b0;
        c_last <= 1'b0;
      end
      if (z_drop) err_ovf <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fv_ct_add.sv
// Directed bench for fv_ct_add at N=4, QW=8, EW=4, DEPTH=4.
module tb_fv_ct_add;

  localparam int unsigned N     = 4;
  localparam int unsigned QW    = 8;
  localparam int unsigned EW    = 4;
  localparam int unsigned DEPTH = 4;

  logic clk = 1'b0;
  logic s_rst;
  logic err_ovf;
  logic err_frame;

  always #5 clk = ~clk;

  axis_if #(.W(QW)) z_if ();
  axis_if #(.W(EW)) e_if ();
  axis_if #(.W(1))  m_if ();
  axis_if #(.W(QW)) c_if ();

  fv_ct_add #(.N(N), .QW(QW), .EW(EW), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .s_rst    (s_rst),
    .z        (z_if),
    .e        (e_if),
    .m        (m_if),
    .c        (c_if),
    .err_ovf  (err_ovf),
    .err_frame(err_frame)
  );

  int n_vec  = 0;
  int n_fail = 0;

  logic [QW:0] got [$];

  always @(posedge clk) begin
    if (c_if.vld === 1'b1 && c_if.rdy === 1'b1) got.push_back({c_if.last, c_if.data});
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic z_beat(input logic [QW-1:0] d, input logic l);
    z_if.vld  = 1'b1;
    z_if.data = d;
    z_if.last = l;
    tick();
    z_if.vld  = 1'b0;
    z_if.last = 1'b0;
  endtask

  task automatic em_beat(input logic [EW-1:0] ed, input logic el, input logic md, input logic ml,
                         output bit ok);
    e_if.vld  = 1'b1;
    e_if.data = ed;
    e_if.last = el;
    m_if.vld  = 1'b1;
    m_if.data = md;
    m_if.last = ml;
    ok = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (e_if.rdy === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    tick();
    e_if.vld  = 1'b0;
    e_if.last = 1'b0;
    m_if.vld  = 1'b0;
    m_if.last = 1'b0;
  endtask

  task automatic test_reset();
    s_rst = 1'b1;
    tick();
    tick();
    n_vec++; if (c_if.vld !== 1'b0)  begin n_fail++; $display("FAIL rst_c_vld got=%b exp=0", c_if.vld); end
    n_vec++; if (c_if.last !== 1'b0) begin n_fail++; $display("FAIL rst_c_last got=%b exp=0", c_if.last); end
    n_vec++; if (c_if.data !== 8'd0) begin n_fail++; $display("FAIL rst_c_data got=%0d exp=0", c_if.data); end
    n_vec++; if (err_ovf !== 1'b0)   begin n_fail++; $display("FAIL rst_err_ovf got=%b exp=0", err_ovf); end
    n_vec++; if (err_frame !== 1'b0) begin n_fail++; $display("FAIL rst_err_frame got=%b exp=0", err_frame); end
    n_vec++; if (z_if.rdy !== 1'b0)  begin n_fail++; $display("FAIL rst_z_rdy got=%b exp=0", z_if.rdy); end
    s_rst = 1'b0;
    n_vec++; if (z_if.rdy !== 1'b0)  begin n_fail++; $display("FAIL st_reset_z_rdy got=%b exp=0", z_if.rdy); end
    tick();
    n_vec++; if (z_if.rdy !== 1'b1)  begin n_fail++; $display("FAIL stream_z_rdy got=%b exp=1", z_if.rdy); end
    n_vec++; if (e_if.rdy !== 1'b0)  begin n_fail++; $display("FAIL stream_e_rdy got=%b exp=0", e_if.rdy); end
  endtask

  task automatic test_basic();
    logic [QW-1:0] zv [4];
    logic [EW-1:0] ev [4];
    logic          mv [4];
    logic [QW-1:0] xv [4];
    zv = '{8'd10, 8'd20, 8'd30, 8'd40};
    ev = '{4'h1, 4'hF, 4'h0, 4'h2};
    mv = '{1'b0, 1'b1, 1'b0, 1'b1};
    xv = '{8'd11, 8'd147, 8'd30, 8'd170};
    for (int i = 0; i < 4; i++) z_beat(zv[i], i == 3);
    for (int i = 0; i < 4; i++) begin
      e_if.vld = 1'b1; e_if.data = ev[i]; e_if.last = (i == 3);
      m_if.vld = 1'b1; m_if.data = mv[i]; m_if.last = (i == 3);
      @(negedge clk);
      n_vec++; if (e_if.rdy !== 1'b1) begin n_fail++; $display("FAIL basic_e_rdy beat %0d got=%b exp=1", i, e_if.rdy); end
      n_vec++; if (m_if.rdy !== 1'b1) begin n_fail++; $display("FAIL basic_m_rdy beat %0d got=%b exp=1", i, m_if.rdy); end
      tick();
      n_vec++; if (c_if.vld !== 1'b1)   begin n_fail++; $display("FAIL basic_c_vld beat %0d got=%b exp=1", i, c_if.vld); end
      n_vec++; if (c_if.data !== xv[i]) begin n_fail++; $display("FAIL basic_c_data beat %0d got=%0d exp=%0d", i, c_if.data, xv[i]); end
      n_vec++; if (c_if.last !== 1'(i == 3)) begin n_fail++; $display("FAIL basic_c_last beat %0d got=%b exp=%b", i, c_if.last, (i == 3)); end
    end
    e_if.vld = 1'b0; e_if.last = 1'b0;
    m_if.vld = 1'b0; m_if.last = 1'b0;
    tick();
    n_vec++; if (c_if.vld !== 1'b0)  begin n_fail++; $display("FAIL basic_drain_vld got=%b exp=0", c_if.vld); end
    n_vec++; if (err_frame !== 1'b0) begin n_fail++; $display("FAIL basic_err_frame got=%b exp=0", err_frame); end
  endtask

  task automatic test_wrap();
    logic [QW-1:0] zv [4];
    logic [EW-1:0] ev [4];
    logic          mv [4];
    logic [QW-1:0] xv [4];
    logic [QW:0]   g;
    bit            ok;
    zv = '{8'd250, 8'd0, 8'd5, 8'd6};
    ev = '{4'h7, 4'hF, 4'h0, 4'h0};
    mv = '{1'b1, 1'b0, 1'b0, 1'b0};
    xv = '{8'd129, 8'd255, 8'd5, 8'd6};
    got.delete();
    for (int i = 0; i < 4; i++) z_beat(zv[i], i == 3);
    for (int i = 0; i < 4; i++) begin
      em_beat(ev[i], i == 3, mv[i], i == 3, ok);
      n_vec++; if (!ok) begin n_fail++; $display("FAIL wrap_fire beat %0d got=0 exp=1", i); end
    end
    repeat (3) tick();
    n_vec++; if (got.size() != 4) begin n_fail++; $display("FAIL wrap_count got=%0d exp=4", got.size()); end
    for (int i = 0; i < 4; i++) begin
      g = (i < got.size()) ? got[i] : 'x;
      n_vec++; if (g !== {1'(i == 3), xv[i]}) begin n_fail++; $display("FAIL wrap_beat %0d got=%h exp=%h", i, g, {1'(i == 3), xv[i]}); end
    end
  endtask

  task automatic test_backpressure();
    logic [QW-1:0] zv [4];
    logic [EW-1:0] ev [4];
    logic          mv [4];
    logic [QW-1:0] xv [4];
    logic [QW:0]   g;
    bit            ok;
    zv = '{8'd100, 8'd101, 8'd102, 8'd103};
    ev = '{4'h3, 4'hE, 4'h5, 4'h8};
    mv = '{1'b1, 1'b0, 1'b1, 1'b1};
    xv = '{8'd231, 8'd99, 8'd235, 8'd223};
    got.delete();
    c_if.rdy = 1'b1;
    for (int i = 0; i < 4; i++) z_beat(zv[i], i == 3);
    em_beat(ev[0], 1'b0, mv[0], 1'b0, ok);
    n_vec++; if (!ok) begin n_fail++; $display("FAIL bp_fire beat 0 got=0 exp=1"); end
    c_if.rdy = 1'b0;
    e_if.vld = 1'b1; e_if.data = ev[1]; e_if.last = 1'b0;
    m_if.vld = 1'b1; m_if.data = mv[1]; m_if.last = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      n_vec++; if (c_if.vld !== 1'b1)   begin n_fail++; $display("FAIL bp_hold_vld cyc %0d got=%b exp=1", k, c_if.vld); end
      n_vec++; if (c_if.data !== xv[0]) begin n_fail++; $display("FAIL bp_hold_data cyc %0d got=%0d exp=%0d", k, c_if.data, xv[0]); end
      n_vec++; if (c_if.last !== 1'b0)  begin n_fail++; $display("FAIL bp_hold_last cyc %0d got=%b exp=0", k, c_if.last); end
      n_vec++; if (e_if.rdy !== 1'b0)   begin n_fail++; $display("FAIL bp_e_rdy cyc %0d got=%b exp=0", k, e_if.rdy); end
      n_vec++; if (m_if.rdy !== 1'b0)   begin n_fail++; $display("FAIL bp_m_rdy cyc %0d got=%b exp=0", k, m_if.rdy); end
    end
    tick();
    c_if.rdy = 1'b1;
    for (int i = 1; i < 4; i++) begin
      em_beat(ev[i], i == 3, mv[i], i == 3, ok);
      n_vec++; if (!ok) begin n_fail++; $display("FAIL bp_fire beat %0d got=0 exp=1", i); end
    end
    repeat (3) tick();
    n_vec++; if (got.size() != 4) begin n_fail++; $display("FAIL bp_count got=%0d exp=4", got.size()); end
    for (int i = 0; i < 4; i++) begin
      g = (i < got.size()) ? got[i] : 'x;
      n_vec++; if (g !== {1'(i == 3), xv[i]}) begin n_fail++; $display("FAIL bp_beat %0d got=%h exp=%h", i, g, {1'(i == 3), xv[i]}); end
    end
  endtask

  task automatic test_overflow();
    logic [QW-1:0] xv [4];
    logic [QW:0]   g;
    bit            ok;
    xv = '{8'd1, 8'd2, 8'd3, 8'd132};
    got.delete();
    for (int i = 0; i < 4; i++) z_beat(8'(i + 1), i == 3);
    n_vec++; if (z_if.rdy !== 1'b0) begin n_fail++; $display("FAIL ovf_full_rdy got=%b exp=0", z_if.rdy); end
    n_vec++; if (err_ovf !== 1'b0)  begin n_fail++; $display("FAIL ovf_pre got=%b exp=0", err_ovf); end
    z_beat(8'd99, 1'b0);
    n_vec++; if (err_ovf !== 1'b1)  begin n_fail++; $display("FAIL ovf_set got=%b exp=1", err_ovf); end
    repeat (3) tick();
    n_vec++; if (err_ovf !== 1'b1)  begin n_fail++; $display("FAIL ovf_sticky got=%b exp=1", err_ovf); end
    for (int i = 0; i < 4; i++) begin
      em_beat(4'h0, i == 3, i == 3, i == 3, ok);
      n_vec++; if (!ok) begin n_fail++; $display("FAIL ovf_fire beat %0d got=0 exp=1", i); end
    end
    repeat (3) tick();
    n_vec++; if (got.size() != 4) begin n_fail++; $display("FAIL ovf_count got=%0d exp=4", got.size()); end
    for (int i = 0; i < 4; i++) begin
      g = (i < got.size()) ? got[i] : 'x;
      n_vec++; if (g !== {1'(i == 3), xv[i]}) begin n_fail++; $display("FAIL ovf_beat %0d got=%h exp=%h", i, g, {1'(i == 3), xv[i]}); end
    end
    n_vec++; if (err_ovf !== 1'b1)   begin n_fail++; $display("FAIL ovf_after got=%b exp=1", err_ovf); end
    n_vec++; if (err_frame !== 1'b0) begin n_fail++; $display("FAIL ovf_frame got=%b exp=0", err_frame); end
  endtask

  task automatic test_framing();
    logic [QW:0] g;
    bit          ok;
    for (int p = 0; p < 2; p++) begin
      got.delete();
      for (int i = 0; i < 4; i++) z_beat(8'(5 + 4 * p + i), i == 3);
      for (int i = 0; i < 4; i++) begin
        em_beat(4'h0, (p == 0) ? (i == 2) : (i == 3), 1'b0, i == 3, ok);
        n_vec++; if (!ok) begin n_fail++; $display("FAIL frame_fire poly %0d beat %0d got=0 exp=1", p, i); end
        n_vec++; if (err_frame !== 1'((p == 1) || (i >= 2))) begin
          n_fail++; $display("FAIL frame_err poly %0d beat %0d got=%b exp=%b", p, i, err_frame, ((p == 1) || (i >= 2)));
        end
      end
      repeat (3) tick();
      n_vec++; if (got.size() != 4) begin n_fail++; $display("FAIL frame_count poly %0d got=%0d exp=4", p, got.size()); end
      for (int i = 0; i < 4; i++) begin
        g = (i < got.size()) ? got[i] : 'x;
        n_vec++; if (g !== {1'(i == 3), 8'(5 + 4 * p + i)}) begin
          n_fail++; $display("FAIL frame_beat poly %0d beat %0d got=%h exp=%h", p, i, g, {1'(i == 3), 8'(5 + 4 * p + i)});
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [QW:0] g;
    bit          ok;
    for (int i = 0; i < 4; i++) z_beat(8'(20 + i), i == 3);
    for (int i = 0; i < 2; i++) em_beat(4'h0, 1'b0, 1'b0, 1'b0, ok);
    s_rst = 1'b1;
    tick();
    n_vec++; if (c_if.vld !== 1'b0)  begin n_fail++; $display("FAIL mid_rst_vld got=%b exp=0", c_if.vld); end
    n_vec++; if (c_if.data !== 8'd0) begin n_fail++; $display("FAIL mid_rst_data got=%0d exp=0", c_if.data); end
    n_vec++; if (err_ovf !== 1'b0)   begin n_fail++; $display("FAIL mid_rst_ovf got=%b exp=0", err_ovf); end
    n_vec++; if (err_frame !== 1'b0) begin n_fail++; $display("FAIL mid_rst_frame got=%b exp=0", err_frame); end
    s_rst = 1'b0;
    got.delete();
    tick();
    e_if.vld = 1'b1; e_if.data = 4'h1; e_if.last = 1'b0;
    m_if.vld = 1'b1; m_if.data = 1'b0; m_if.last = 1'b0;
    @(negedge clk);
    n_vec++; if (e_if.rdy !== 1'b0) begin n_fail++; $display("FAIL mid_fifo_empty got=%b exp=0", e_if.rdy); end
    n_vec++; if (z_if.rdy !== 1'b1) begin n_fail++; $display("FAIL mid_z_rdy got=%b exp=1", z_if.rdy); end
    tick();
    e_if.vld = 1'b0;
    m_if.vld = 1'b0;
    for (int i = 0; i < 4; i++) z_beat(8'(40 + i), i == 3);
    for (int i = 0; i < 4; i++) begin
      em_beat(4'h1, i == 3, 1'b0, i == 3, ok);
      n_vec++; if (!ok) begin n_fail++; $display("FAIL mid_fire beat %0d got=0 exp=1", i); end
    end
    repeat (3) tick();
    n_vec++; if (got.size() != 4) begin n_fail++; $display("FAIL mid_count got=%0d exp=4", got.size()); end
    for (int i = 0; i < 4; i++) begin
      g = (i < got.size()) ? got[i] : 'x;
      n_vec++; if (g !== {1'(i == 3), 8'(41 + i)}) begin
        n_fail++; $display("FAIL mid_beat %0d got=%h exp=%h", i, g, {1'(i == 3), 8'(41 + i)});
      end
    end
    n_vec++; if (err_frame !== 1'b0) begin n_fail++; $display("FAIL mid_frame_after got=%b exp=0", err_frame); end
  endtask

  initial begin
    s_rst     = 1'b1;
    z_if.vld  = 1'b0; z_if.data = '0; z_if.last = 1'b0;
    e_if.vld  = 1'b0; e_if.data = '0; e_if.last = 1'b0;
    m_if.vld  = 1'b0; m_if.data = '0; m_if.last = 1'b0;
    c_if.rdy  = 1'b1;
    test_reset();
    test_basic();
    test_wrap();
    test_backpressure();
    test_overflow();
    test_framing();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
